// File: rtl/z3_slave_sequencer.sv
// Zorro III slave cycle sequencer: walks one bus cycle from FCS through data
// phase to DTACK or BERR, with per-cycle timeout and a saturating error count.
module z3_slave_sequencer #(
  parameter int NUM_REGIONS   = 5,
  parameter int TIMEOUT       = 200,
  parameter int TO_W          = 8,
  parameter int DTACK_HOLDOFF = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FCS_n,
  input  logic                   MATCH,
  input  logic                   VALIDSPACE,
  input  logic                   READ,
  input  logic [3:0]             DS_n,
  input  logic [NUM_REGIONS-1:0] region_sel,
  input  logic [NUM_REGIONS-1:0] region_ack,
  output logic [NUM_REGIONS-1:0] region_req,
  output logic                   dtack,
  output logic                   berr,
  output logic                   busy,
  output logic [7:0]             err_count
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_ERR} state_t;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [1:0]      HOLD_LAST = (DTACK_HOLDOFF > 0) ? 2'(DTACK_HOLDOFF - 1) : 2'd0;

  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] req_q, req_d;
  logic                   unmapped_q, unmapped_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [1:0]             hold_q, hold_d;
  logic                   dtack_q, dtack_d;
  logic                   berr_q, berr_d;
  logic                   busy_q, busy_d;
  logic [7:0]             err_q, err_d, err_inc;

  // Lowest-index region wins when the decode overlaps.
  function automatic logic [NUM_REGIONS-1:0] first_one(input logic [NUM_REGIONS-1:0] v);
    first_one = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        first_one    = '0;
        first_one[i] = 1'b1;
      end
    end
  endfunction

  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    unmapped_d = unmapped_q;
    to_d       = to_q;
    hold_d     = hold_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        dtack_d = 1'b0;
        berr_d  = 1'b0;
        req_d   = '0;
        to_d    = '0;
        hold_d  = '0;
        if (!FCS_n && MATCH && VALIDSPACE) begin
          state_d    = S_START;
          req_d      = first_one(region_sel);
          unmapped_d = (region_sel == '0);
        end
      end
      S_START: begin
        if (FCS_n) begin
          state_d = S_IDLE;
          req_d   = '0;
        end else if (READ || DS_n != 4'hF) begin
          if (unmapped_q) begin
            state_d = S_ERR;
            berr_d  = 1'b1;
            err_d   = err_inc;
          end else begin
            state_d = S_DATA;
            to_d    = '0;
          end
        end
      end
      S_DATA: begin
        // Ack is checked before the timeout so a same-edge ack completes the cycle.
        if (FCS_n) begin
          state_d = S_IDLE;
          req_d   = '0;
          to_d    = '0;
        end else if (|(region_ack & req_q)) begin
          state_d = S_END;
          hold_d  = '0;
          dtack_d = (DTACK_HOLDOFF == 0);
        end else if (to_q == TO_LAST) begin
          state_d = S_ERR;
          berr_d  = 1'b1;
          err_d   = err_inc;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_END: begin
        if (FCS_n) begin
          state_d = S_IDLE;
          dtack_d = 1'b0;
          req_d   = '0;
          hold_d  = '0;
          to_d    = '0;
        end else if (!dtack_q) begin
          if (hold_q == HOLD_LAST) dtack_d = 1'b1;
          else                     hold_d  = hold_q + 2'd1;
        end
      end
      S_ERR: begin
        if (FCS_n) begin
          state_d = S_IDLE;
          berr_d  = 1'b0;
          req_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      unmapped_q <= 1'b0;
      to_q       <= '0;
      hold_q     <= '0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      unmapped_q <= unmapped_d;
      to_q       <= to_d;
      hold_q     <= hold_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign region_req = req_q;
  assign dtack      = dtack_q;
  assign berr       = berr_q;
  assign busy       = busy_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_z3_slave_sequencer.sv
// Bench for z3_slave_sequencer: directed and randomized bus cycles checked
// against a transaction-level outcome model (END vs ERR, edge of completion).
module tb_z3_slave_sequencer;

  localparam int N  = 5;
  localparam int TO = 200;
  localparam int H  = 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         FCS_n, MATCH, VALIDSPACE, READ;
  logic [3:0]   DS_n;
  logic [N-1:0] region_sel, region_ack, region_req;
  logic         dtack, berr, busy;
  logic [7:0]   err_count;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_err = 8'd0;

  always #20 CLK = ~CLK;

  z3_slave_sequencer #(
    .NUM_REGIONS(N), .TIMEOUT(TO), .TO_W(8), .DTACK_HOLDOFF(H)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FCS_n(FCS_n), .MATCH(MATCH),
    .VALIDSPACE(VALIDSPACE), .READ(READ), .DS_n(DS_n),
    .region_sel(region_sel), .region_ack(region_ack), .region_req(region_req),
    .dtack(dtack), .berr(berr), .busy(busy), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b0) begin
      tests++;
      assert (!(dtack && berr)) else begin
        fails++;
        $error("FAIL excl: observed dtack=%0b berr=%0b expected not both", dtack, berr);
      end
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_flags"}, {dtack, berr}, 2'b00);
    chk({tag, "_req"}, region_req, '0);
    chk({tag, "_err"}, err_count, exp_err);
  endtask

  // One bus cycle. ackv is presented from DATA edge j onward; hold_n cycles
  // of FCS low follow the terminal state before FCS is released.
  task automatic do_cycle(input logic [N-1:0] sel, input bit wr, input int lag,
                          input logic [N-1:0] ackv, input int j,
                          input bit abort_start, input int hold_n);
    logic [N-1:0] exp_req;
    bit hit, ended;
    int eff_lag;
    exp_req = sel & (~sel + 5'd1);
    hit     = ((ackv & exp_req) != '0) && (j <= TO);
    eff_lag = wr ? lag : 0;
    ended   = 1'b0;
    FCS_n = 1'b0; MATCH = 1'b1; VALIDSPACE = 1'b1; READ = !wr;
    DS_n = (eff_lag > 0) ? 4'hF : 4'h0;
    region_sel = sel; region_ack = '0;
    tick();
    chk("start_req", region_req, exp_req);
    chk("start_busy", busy, 1'b1);
    chk("start_flags", {dtack, berr}, 2'b00);
    region_sel = N'($urandom);
    for (int i = 0; i < eff_lag; i++) begin
      tick();
      chk("start_wait", {dtack, berr, busy}, 3'b001);
    end
    if (abort_start) begin
      FCS_n = 1'b1;
      tick();
      chk_idle("abort");
      return;
    end
    DS_n = 4'h0;
    tick();
    if (sel == '0) begin
      exp_err = sat_inc(exp_err);
      chk("unmapped_berr", {dtack, berr}, 2'b01);
      chk("unmapped_err", err_count, exp_err);
    end else begin
      chk("data_entry", {dtack, berr, busy}, 3'b001);
      for (int e = 1; e <= TO; e++) begin
        region_ack = (e >= j) ? ackv : '0;
        tick();
        if (hit && e == j) begin
          ended = 1'b1;
          break;
        end
        if (e == TO) break;
        chk("data_wait", {dtack, berr}, 2'b00);
      end
      if (ended) begin
        chk("end_entry", {dtack, berr}, {(H == 0), 1'b0});
        for (int h = 1; h <= H; h++) begin
          tick();
          chk("holdoff", dtack, (h == H));
        end
      end else begin
        exp_err = sat_inc(exp_err);
        chk("timeout_berr", {dtack, berr}, 2'b01);
        chk("timeout_err", err_count, exp_err);
      end
    end
    for (int k = 0; k < hold_n; k++) begin
      region_ack = N'($urandom);
      tick();
      chk("held_flags", {dtack, berr}, ended ? 2'b10 : 2'b01);
      chk("held_req", region_req, exp_req);
      chk("held_err", err_count, exp_err);
    end
    FCS_n = 1'b1; region_ack = '0;
    tick();
    chk_idle("release");
    tick();
    chk_idle("gap");
  endtask

  initial begin
    RESET = 1'b1; FCS_n = 1'b1; MATCH = 1'b0; VALIDSPACE = 1'b0; READ = 1'b0;
    DS_n = 4'hF; region_sel = '0; region_ack = '0;
    tick(); tick();
    chk_idle("reset");
    RESET = 1'b0;
    tick();
    chk_idle("post_reset");

    // Qualifiers must all be present to start a cycle.
    FCS_n = 1'b0; MATCH = 1'b0; VALIDSPACE = 1'b1; region_sel = 5'b00001;
    tick();
    chk_idle("no_match");
    MATCH = 1'b1; VALIDSPACE = 1'b0;
    tick();
    chk_idle("no_space");
    FCS_n = 1'b1;
    tick();

    do_cycle(5'b00100, 1'b0, 0, 5'b00100, 3, 1'b0, 2);     // read hit, region 2
    do_cycle(5'b00001, 1'b1, 4, 5'b00001, 2, 1'b0, 1);     // write, lagging strobes
    do_cycle(5'b00100, 1'b0, 0, 5'b00000, TO + 1, 1'b0, 2); // no ack: timeout
    do_cycle(5'b00000, 1'b0, 0, 5'b11111, 1, 1'b0, 3);     // unmapped
    do_cycle(5'b10110, 1'b0, 0, 5'b10000, 1, 1'b0, 1);     // foreign ack ignored
    do_cycle(5'b10110, 1'b0, 0, 5'b00010, TO, 1'b0, 1);    // ack on timeout edge
    do_cycle(5'b01000, 1'b1, 2, 5'b01000, 1, 1'b1, 0);     // abort in START

    // Reset mid-END with dtack high, then a fresh cycle with FCS still low.
    FCS_n = 1'b0; MATCH = 1'b1; VALIDSPACE = 1'b1; READ = 1'b1; DS_n = 4'h0;
    region_sel = 5'b00001; region_ack = '0;
    tick(); tick();
    region_ack = 5'b00001;
    tick(); tick();
    chk("pre_reset_dtack", dtack, 1'b1);
    #5 RESET = 1'b1;
    #1;
    exp_err = 8'd0;
    chk("async_dtack", dtack, 1'b0);
    chk("async_req", region_req, '0);
    chk("async_busy", busy, 1'b0);
    chk("async_err", err_count, 8'd0);
    region_sel = 5'b00010; region_ack = '0;
    tick();
    RESET = 1'b0;
    tick();
    chk("restart_busy", busy, 1'b1);
    chk("restart_req", region_req, 5'b00010);
    tick();
    region_ack = 5'b00010;
    tick(); tick();
    chk("restart_dtack", dtack, 1'b1);
    FCS_n = 1'b1; region_ack = '0;
    tick();
    chk_idle("restart_release");
    tick();

    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] s, a;
      int j, lg, hd;
      bit w, ab;
      s  = N'($urandom_range(0, 31));
      a  = N'($urandom_range(0, 31));
      w  = 1'($urandom_range(0, 1));
      lg = $urandom_range(0, 5);
      j  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 5, TO + 5) : $urandom_range(1, 8);
      ab = ($urandom_range(0, 9) == 0);
      hd = $urandom_range(0, 3);
      do_cycle(s, w, lg, a, j, ab, hd);
    end

    for (int t = 0; t < 256; t++) do_cycle(5'b00001, 1'b0, 0, 5'b00000, TO + 1, 1'b0, 0);
    chk("saturate", err_count, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
